rx_stats_snapshot: RTL and testbench
====================================

Name: rx_stats_snapshot

Overview:
- Accumulates per-frame receive statistics (good frames, bad frames, good bytes) in the MAC clock domain.
- Publishes them as periodic, stable snapshot buses that feed the multi-bit slow-to-fast clock-domain synchronizer stage downstream.
- Each snapshot is held constant for at least PERIOD cycles, so the downstream synchronizer always sees a settled bus. It never samples mid-update.

Parameters:
- CNT_W, 32, width of every counter and snapshot bus.
- LEN_W, 14, width of the frame-length input in bytes.
- PERIOD, 256, snapshot interval in clk cycles. Legal range is 8 to 2^16. Values below 8 break the synchronizer hold requirement.
- SATURATE, 1, 1 = counters stick at all-ones; 0 = counters wrap modulo 2^CNT_W.

Ports:
- clk, input, 1, MAC-domain clock.
- rst, input, 1, synchronous active-high reset.
- ev_valid, input, 1, one-cycle frame-end event strobe.
- ev_good, input, 1, qualifies ev_valid: 1 = good frame, 0 = bad frame (CRC, length or other error).
- ev_len, input, LEN_W, byte length of the frame. Only meaningful when ev_valid=1.
- clear, input, 1, one-cycle request to zero the live counters.
- snap_good_frames, output, CNT_W, snapshot of the good-frame count.
- snap_bad_frames, output, CNT_W, snapshot of the bad-frame count.
- snap_good_bytes, output, CNT_W, snapshot of the good-byte count.
- snap_stb, output, 1, one-cycle pulse in the cycle after the snapshot registers load.

Behaviour:
- Reset (synchronous, rst=1 sampled at a clk edge):
  - live counters, snapshot outputs, period counter and snap_stb all go to 0.
  - FSM goes to INIT.
- FSM states:
  - INIT: lasts one cycle after reset is released. Events arriving in this cycle are ignored. Next state is RUN.
  - RUN: accumulates events and advances the period counter.
  - SNAP: lasts one cycle. Loads the snapshot registers, then returns to RUN.
- Accumulation (RUN and SNAP):
  - ev_valid & ev_good: good_frames += 1; good_bytes += ev_len, with ev_len zero-extended.
  - ev_valid & ~ev_good: bad_frames += 1; ev_len is ignored.
- Arithmetic:
  - SATURATE=1: any sum that would exceed 2^CNT_W-1 yields 2^CNT_W-1. Once saturated, a counter stays there until clear or rst.
  - SATURATE=0: plain modular add.
- Period counter:
  - Counts 0..PERIOD-1 in RUN.
  - When it reaches PERIOD-1, the FSM goes to SNAP on the next edge and the counter wraps to 0.
  - The interval between successive SNAP cycles is exactly PERIOD+1 cycles. The period counter holds during SNAP.
- SNAP cycle:
  - Snapshot registers take the live counter values present at the start of the cycle.
  - An event arriving in the SNAP cycle is added to the live counters but is excluded from this snapshot; it appears in the next one.
  - snap_stb=1 in the following cycle.
- Snapshot outputs change only at SNAP edges. All three buses update on the same edge.
- clear:
  - Zeroes all live counters and resets the period counter to 0. Snapshots are untouched.
  - clear together with ev_valid in the same cycle: the result equals that single event applied to zero (e.g. good, len 60 gives frames=1, bytes=60).
  - clear during the SNAP cycle: the snapshot still captures the pre-clear values; the live counters and period counter are zeroed.
  - clear during INIT has no additional effect.
- Reset mid-period: all state is lost and outputs return to 0 immediately at that edge. No snap_stb is generated by the reset.
- Latency: event to visibility on the snapshot bus is at most PERIOD+2 cycles.
- Downstream note: unchanged snapshot values are permitted. The synchronizer only forwards changes, and its outputs reset to 0, consistent with the snapshot reset values.

Test Plan:
- PERIOD=16, SATURATE=1; release rst; 3 good events with len 64, 128, 1500, plus 1 bad event with len 99, all before the first SNAP. Required at the first snap_stb: good_frames=3, bad_frames=1, good_bytes=1692. The next snapshot is unchanged if no further events arrive.
- Event (good, len 60) driven exactly in the SNAP cycle. Required: that snapshot excludes it; the next snapshot includes frames+1 and bytes+60. Also check snap_stb spacing is exactly 17 cycles.
- clear asserted together with a good event (len 60) mid-period. Required: next snapshot shows good_frames=1, bad_frames=0, good_bytes=60; the first snap_stb comes 17 cycles after clear. Snapshots taken before the clear stay unchanged until then.
- CNT_W=8, SATURATE=1; 300 good events with len 1. Required: good_frames=255 and good_bytes=255, holding. Repeat with SATURATE=0: both must equal 44 (300 mod 256).
- rst pulsed for 1 cycle mid-period with nonzero snapshots. Required: all snapshots 0 at that edge and no snap_stb. An event in the INIT cycle is not counted. The first new snap_stb comes 1 (INIT) + 16 (RUN) + 1 (SNAP) cycles after reset release.
- Chained with the synchronizer (clk_out ≥ 1.5× clk): random events over 50 periods. Required: the destination bus equals each snapshot value, the destination never shows a value mixing bits of two snapshots, and every snapshot change that differs from the previous value appears within PERIOD cycles.

Source files
------------

// File: rtl/rx_stats_snapshot.sv
// rx_stats_snapshot: receive frame statistics for the MAC clock domain.
// Live counters are copied into held snapshot buses every PERIOD+1 cycles
// so a slow-to-fast multi-bit synchronizer downstream always samples a
// settled value.
//
// Ports:
//   clk, rst            MAC clock, synchronous active-high reset
//   ev_valid/ev_good    frame-end strobe and good/bad qualifier
//   ev_len              frame length in bytes (valid with ev_valid)
//   clear               zero the live counters and the period counter
//   snap_good_frames    snapshot of the good-frame count
//   snap_bad_frames     snapshot of the bad-frame count
//   snap_good_bytes     snapshot of the good-byte count
//   snap_stb            pulse in the cycle after the snapshots load
module rx_stats_snapshot #(
    parameter int CNT_W    = 32,
    parameter int LEN_W    = 14,
    parameter int PERIOD   = 256,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ev_valid,
    input  logic             ev_good,
    input  logic [LEN_W-1:0] ev_len,
    input  logic             clear,
    output logic [CNT_W-1:0] snap_good_frames,
    output logic [CNT_W-1:0] snap_bad_frames,
    output logic [CNT_W-1:0] snap_good_bytes,
    output logic             snap_stb
);

    localparam int PER_W = $clog2(PERIOD);
    // One guard bit above the wider operand catches any overflow.
    localparam int SUM_W = ((CNT_W > LEN_W) ? CNT_W : LEN_W) + 1;
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD - 1);
    localparam logic [SUM_W-1:0] ONE = SUM_W'(1);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_SNAP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] gf_q, gf_d;
    logic [CNT_W-1:0] bf_q, bf_d;
    logic [CNT_W-1:0] gb_q, gb_d;
    logic [CNT_W-1:0] snap_gf_q, snap_bf_q, snap_gb_q;
    logic             stb_q;
    logic [SUM_W-1:0] len_ext;

    assign len_ext = SUM_W'(ev_len);

    function automatic logic [CNT_W-1:0] acc_add(
        input logic [CNT_W-1:0] a,
        input logic [SUM_W-1:0] b
    );
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(a) + b;
        if (SATURATE && (|sum[SUM_W-1:CNT_W])) begin
            return '1;
        end
        return sum[CNT_W-1:0];
    endfunction

    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        gf_d    = gf_q;
        bf_d    = bf_q;
        gb_d    = gb_q;

        unique case (state_q)
            ST_INIT: state_d = ST_RUN;
            ST_RUN: begin
                // clear restarts the interval, so it also cancels a
                // snapshot that would otherwise be due next cycle.
                if (clear) begin
                    per_d = '0;
                end else if (per_q == PER_LAST) begin
                    per_d   = '0;
                    state_d = ST_SNAP;
                end else begin
                    per_d = per_q + PER_W'(1);
                end
            end
            ST_SNAP: begin
                state_d = ST_RUN;
                if (clear) begin
                    per_d = '0;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // clear zeroes first so a same-cycle event lands on zero.
        if (state_q != ST_INIT) begin
            if (clear) begin
                gf_d = '0;
                bf_d = '0;
                gb_d = '0;
            end
            if (ev_valid) begin
                if (ev_good) begin
                    gf_d = acc_add(gf_d, ONE);
                    gb_d = acc_add(gb_d, len_ext);
                end else begin
                    bf_d = acc_add(bf_d, ONE);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_INIT;
            per_q     <= '0;
            gf_q      <= '0;
            bf_q      <= '0;
            gb_q      <= '0;
            snap_gf_q <= '0;
            snap_bf_q <= '0;
            snap_gb_q <= '0;
            stb_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            gf_q    <= gf_d;
            bf_q    <= bf_d;
            gb_q    <= gb_d;
            stb_q   <= (state_q == ST_SNAP);
            // Capture the values present at the start of SNAP; an
            // event or clear in this cycle only reaches the live set.
            if (state_q == ST_SNAP) begin
                snap_gf_q <= gf_q;
                snap_bf_q <= bf_q;
                snap_gb_q <= gb_q;
            end
        end
    end

    assign snap_good_frames = snap_gf_q;
    assign snap_bad_frames  = snap_bf_q;
    assign snap_good_bytes  = snap_gb_q;
    assign snap_stb         = stb_q;

endmodule

// File: tb/tb_rx_stats_snapshot.sv
// tb_rx_stats_snapshot: scoreboard bench for rx_stats_snapshot.
// Three instances share stimulus: 32-bit saturating, 8-bit saturating, 8-bit wrapping.
module tb_rx_stats_snapshot;

    localparam int PERIOD  = 16;
    localparam int SPACING = PERIOD + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ev_valid = 1'b0;
    logic        ev_good = 1'b0;
    logic [13:0] ev_len = '0;
    logic        clear = 1'b0;

    logic [31:0] a_gf, a_bf, a_gb;
    logic        a_stb;
    logic [7:0]  s_gf, s_bf, s_gb;
    logic        s_stb;
    logic [7:0]  w_gf, w_bf, w_gb;
    logic        w_stb;

    always #5 clk = ~clk;

    rx_stats_snapshot #(
        .CNT_W(32), .LEN_W(14), .PERIOD(PERIOD), .SATURATE(1'b1)
    ) u_a (
        .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_good(ev_good),
        .ev_len(ev_len), .clear(clear),
        .snap_good_frames(a_gf), .snap_bad_frames(a_bf),
        .snap_good_bytes(a_gb), .snap_stb(a_stb)
    );

    rx_stats_snapshot #(
        .CNT_W(8), .LEN_W(14), .PERIOD(PERIOD), .SATURATE(1'b1)
    ) u_s (
        .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_good(ev_good),
        .ev_len(ev_len), .clear(clear),
        .snap_good_frames(s_gf), .snap_bad_frames(s_bf),
        .snap_good_bytes(s_gb), .snap_stb(s_stb)
    );

    rx_stats_snapshot #(
        .CNT_W(8), .LEN_W(14), .PERIOD(PERIOD), .SATURATE(1'b0)
    ) u_w (
        .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_good(ev_good),
        .ev_len(ev_len), .clear(clear),
        .snap_good_frames(w_gf), .snap_bad_frames(w_bf),
        .snap_good_bytes(w_gb), .snap_stb(w_stb)
    );

    typedef struct packed {
        logic [31:0] gf;
        logic [31:0] bf;
        logic [31:0] gb;
    } cnt3_t;

    typedef struct packed {
        cnt3_t a;
        cnt3_t s;
        cnt3_t w;
    } snap_t;

    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned edge_n = 0;
    int unsigned m_next = 0;
    int unsigned rst_edge = 0;
    int unsigned rst_cnt = 0;
    int unsigned seen_rst = 0;
    bit          armed = 1'b0;
    bit          m_init = 1'b0;
    snap_t       live = '0;
    snap_t       shown = '0;
    snap_t       exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] madd(input logic [31:0] a,
                                         input logic [31:0] d,
                                         input int w, input bit sat);
        logic [63:0] mx;
        logic [63:0] s;
        mx = (64'd1 << w) - 64'd1;
        s = {32'd0, a} + {32'd0, d};
        if (s <= mx) return s[31:0];
        if (sat) return mx[31:0];
        s = s & mx;
        return s[31:0];
    endfunction

    function automatic cnt3_t apply(input cnt3_t c, input int w,
                                    input bit sat, input bit g,
                                    input logic [13:0] len);
        cnt3_t r;
        r = c;
        if (g) begin
            r.gf = madd(r.gf, 32'd1, w, sat);
            r.gb = madd(r.gb, {18'd0, len}, w, sat);
        end else begin
            r.bf = madd(r.bf, 32'd1, w, sat);
        end
        return r;
    endfunction

    // Reference: snapshots fall due every SPACING edges, counted from the
    // end of INIT or from the last snapshot or clear edge.
    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            armed = 1'b1;
            m_init = 1'b1;
            live = '0;
            exp_q.delete();
            rst_edge = edge_n;
            rst_cnt++;
        end else if (m_init) begin
            m_init = 1'b0;
            m_next = edge_n + SPACING;
        end else if (armed) begin
            if (edge_n == m_next) begin
                exp_q.push_back(live);
                m_next = edge_n + SPACING;
            end
            if (clear) begin
                live = '0;
                m_next = edge_n + SPACING;
            end
            if (ev_valid) begin
                live.a = apply(live.a, 32, 1'b1, ev_good, ev_len);
                live.s = apply(live.s, 8, 1'b1, ev_good, ev_len);
                live.w = apply(live.w, 8, 1'b0, ev_good, ev_len);
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            bit exp_stb;
            if (rst_cnt != seen_rst) begin
                shown = '0;
                seen_rst = rst_cnt;
            end
            exp_stb = (exp_q.size() > 0);
            chk("a_stb", {63'd0, a_stb}, {63'd0, exp_stb});
            chk("s_stb", {63'd0, s_stb}, {63'd0, exp_stb});
            chk("w_stb", {63'd0, w_stb}, {63'd0, exp_stb});
            if (exp_stb) shown = exp_q.pop_front();
            chk("a_gf", {32'd0, a_gf}, {32'd0, shown.a.gf});
            chk("a_bf", {32'd0, a_bf}, {32'd0, shown.a.bf});
            chk("a_gb", {32'd0, a_gb}, {32'd0, shown.a.gb});
            chk("s_gf", {56'd0, s_gf}, {32'd0, shown.s.gf});
            chk("s_bf", {56'd0, s_bf}, {32'd0, shown.s.bf});
            chk("s_gb", {56'd0, s_gb}, {32'd0, shown.s.gb});
            chk("w_gf", {56'd0, w_gf}, {32'd0, shown.w.gf});
            chk("w_bf", {56'd0, w_bf}, {32'd0, shown.w.bf});
            chk("w_gb", {56'd0, w_gb}, {32'd0, shown.w.gb});
        end
    end

    task automatic step(input bit v, input bit g, input int len,
                        input bit clr);
        @(negedge clk);
        ev_valid = v;
        ev_good = g;
        ev_len = 14'(len);
        clear = clr;
    endtask

    // Idles the inputs from the next negedge on and waits for a strobe.
    task automatic wait_stb(output int unsigned at);
        at = 0;
        for (int i = 0; i < 3 * SPACING; i++) begin
            @(negedge clk);
            ev_valid = 1'b0;
            clear = 1'b0;
            if (a_stb) begin
                at = edge_n;
                return;
            end
        end
        chk("stb_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned e1, e2, e3, e4, c_edge, r_edge;

        repeat (3) @(negedge clk);
        rst = 1'b0;

        step(1'b1, 1'b1, 64, 1'b0);
        step(1'b1, 1'b1, 128, 1'b0);
        step(1'b1, 1'b1, 1500, 1'b0);
        step(1'b1, 1'b0, 99, 1'b0);
        wait_stb(e1);
        chk("t1_gf", {32'd0, a_gf}, 64'd3);
        chk("t1_bf", {32'd0, a_bf}, 64'd1);
        chk("t1_gb", {32'd0, a_gb}, 64'd1692);
        chk("t1_first", 64'(e1 - rst_edge), 64'd18);
        wait_stb(e2);
        chk("t1_hold_gf", {32'd0, a_gf}, 64'd3);
        chk("t1_hold_gb", {32'd0, a_gb}, 64'd1692);
        chk("t1_space", 64'(e2 - e1), 64'd17);

        repeat (15) step(1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b1, 60, 1'b0);
        wait_stb(e3);
        chk("t2_excl_gf", {32'd0, a_gf}, 64'd3);
        chk("t2_excl_gb", {32'd0, a_gb}, 64'd1692);
        chk("t2_space", 64'(e3 - e2), 64'd17);
        wait_stb(e4);
        chk("t2_incl_gf", {32'd0, a_gf}, 64'd4);
        chk("t2_incl_gb", {32'd0, a_gb}, 64'd1752);
        chk("t2_space2", 64'(e4 - e3), 64'd17);

        repeat (5) step(1'b0, 1'b0, 0, 1'b0);
        chk("t3_pre_gf", {32'd0, a_gf}, 64'd4);
        chk("t3_pre_gb", {32'd0, a_gb}, 64'd1752);
        step(1'b1, 1'b1, 60, 1'b1);
        c_edge = edge_n + 1;
        wait_stb(e1);
        chk("t3_gf", {32'd0, a_gf}, 64'd1);
        chk("t3_bf", {32'd0, a_bf}, 64'd0);
        chk("t3_gb", {32'd0, a_gb}, 64'd60);
        chk("t3_lat", 64'(e1 - c_edge), 64'd17);

        step(1'b0, 1'b0, 0, 1'b1);
        repeat (300) step(1'b1, 1'b1, 1, 1'b0);
        wait_stb(e1);
        wait_stb(e2);
        chk("t4_sat_gf", {56'd0, s_gf}, 64'd255);
        chk("t4_sat_gb", {56'd0, s_gb}, 64'd255);
        chk("t4_wrap_gf", {56'd0, w_gf}, 64'd44);
        chk("t4_wrap_gb", {56'd0, w_gb}, 64'd44);
        chk("t4_wide_gf", {32'd0, a_gf}, 64'd300);
        wait_stb(e3);
        chk("t4_sat_hold", {56'd0, s_gf}, 64'd255);

        repeat (4) step(1'b0, 1'b0, 0, 1'b0);
        chk("t5_pre_gf", {32'd0, a_gf}, 64'd300);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ev_valid = 1'b1;
        ev_good = 1'b1;
        ev_len = 14'd500;
        r_edge = edge_n;
        chk("t5_rst_gf", {32'd0, a_gf}, 64'd0);
        chk("t5_rst_gb", {32'd0, a_gb}, 64'd0);
        chk("t5_rst_sgb", {56'd0, s_gb}, 64'd0);
        chk("t5_rst_stb", {63'd0, a_stb}, 64'd0);
        wait_stb(e1);
        chk("t5_first", 64'(e1 - r_edge), 64'd18);
        chk("t5_init_gf", {32'd0, a_gf}, 64'd0);
        chk("t5_init_gb", {32'd0, a_gb}, 64'd0);

        for (int i = 0; i < 20 * SPACING; i++) begin
            int len;
            len = ($urandom_range(0, 9) == 0) ? 16383
                                              : int'($urandom_range(0, 2000));
            step($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                 len, $urandom_range(0, 59) == 0);
        end
        wait_stb(e1);
        wait_stb(e2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
